disp_share_arbiter: RTL and testbench
=====================================

# disp_share_arbiter

Time-shares the 8-digit seven-segment display path among up to N_REQ requesters (ALU result, status codes, debug counters). Requesters raise a level request with a 32-bit hex value and an 8-bit digit-enable mask. The block grants one owner at a time using round-robin with minimum and maximum dwell times. It inserts a blank gap between owners and drives a single registered data word and mask toward the display driver.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- MIN_HOLD, 4: minimum cycles an owner keeps the grant, ≥1.
- MAX_HOLD, 16: cycles after which a pending competitor forces rotation, ≥MIN_HOLD.
- GAP_CYCLES, 2: blank cycles between owners, ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester.
- req_data  in  32*N_REQ  hex value, lane i = bits [32i+31:32i].
- req_mask  in  8*N_REQ  digit enables, lane i = bits [8i+7:8i], 1 = digit lit.
- grant  out  N_REQ  one-hot current owner, all-zero when none.
- owner  out  $clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high in GRANT and GAP.
- disp_data  out  32  value to the display driver.
- disp_mask  out  8  digit enables to the display driver; 0 blanks all digits.

## Operation
- States: IDLE, GRANT, GAP.
- Round-robin search starts at last_owner+1 and wraps modulo N_REQ. The winner is the first index with req high.
- IDLE: grant=0, disp_data=0, disp_mask=0.
  - If any req is high, load winner and go to GRANT with timer=0.
- GRANT: grant=onehot(owner). disp_data and disp_mask register the owner's lane every cycle. The timer increments and saturates at MAX_HOLD-1.
  - Exit to GAP when timer ≥ MIN_HOLD-1 and either condition holds:
    - req[owner] is low, or
    - timer ≥ MAX_HOLD-1 and any other req is high.
  - If the owner drops req before MIN_HOLD, it keeps the grant until MIN_HOLD cycles have elapsed. The display keeps tracking its lane.
  - A sole requester never rotates. It holds indefinitely with the timer saturated.
- GAP: grant=0, disp_mask=0, disp_data=0. The gap counter runs GAP_CYCLES cycles.
  - On the last cycle, if any req is high, arbitrate and go to GRANT. Otherwise go to IDLE.
  - The previous owner may win again only if no other requester is high.
- last_owner updates on each entry to GRANT.
- Reset sets:
  - state IDLE;
  - all outputs 0;
  - last_owner = N_REQ-1, so req[0] wins first;
  - both counters to 0.
- Reset mid-grant drops grant in the next cycle.

## Timing
- req is sampled at edge t. grant, owner and the first disp_data/disp_mask appear after edge t (one-cycle latency from IDLE).
- Changes on the owner's lane appear on disp_data one cycle later.
- A grant lasts at least MIN_HOLD cycles. With a competitor pending and the owner still requesting, it lasts exactly MAX_HOLD cycles.
- The owner-to-owner handoff has exactly GAP_CYCLES cycles with grant=0 and disp_mask=0.
- busy is registered and aligned with the state.
- No combinational path exists from req to grant.

## Configuration
- DISP_ARB_PREEMPT_EN defined: requester 0 is urgent.
  - If req[0] is high while another index owns in GRANT with timer ≥ MIN_HOLD-1, the block exits to GAP the next cycle.
  - Arbitration after any GAP checks index 0 first.
- Undefined: index 0 is an ordinary round-robin participant.

## Structure
- Package disp_arb_pkg holds:
  - the state typedef (IDLE, GRANT, GAP);
  - the blank constants (32'h0 data, 8'h00 mask).
- Sub-module rr_pick: combinational round-robin search. Inputs are req and last_owner; outputs are the winner index and an any-request flag.
- The FSM, timers and output registers stay in the top block.

## Test plan
- Single request: reset, then req=4'b0010 with lane1=32'hDEADBEEF, mask 8'hFF.
  - Grant 4'b0010 appears one cycle later, with disp_data=DEADBEEF and busy=1.
  - Grant is held indefinitely.
- Rotation: req=4'b0011 held. Owners alternate 0,1,0 with grants of exactly 16 cycles and 2-cycle blank gaps (disp_mask=0).
- Early release: owner 2 drops req after 1 cycle. Grant persists 4 cycles total, then GAP, then IDLE with all outputs 0.
- Wrap-around: last owner 3, req=4'b1001 pending. Next owner is 0, then 3.
- Reset mid-grant: reset while owner 1 holds. All outputs are 0 next cycle, and a later req=4'b1111 grants 0 first.
- Preempt with DISP_ARB_PREEMPT_EN: owner 2 at timer 5, req[0] rises. GAP starts the next cycle, then owner 0. Without the macro, owner 2 holds until MAX_HOLD.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// -----------------------------------------------------------------------------
// disp_arb_pkg
// Shared definitions for the display-sharing arbiter:
//   - state_t     : arbiter FSM states (IDLE, GRANT, GAP)
//   - BLANK_DATA  : data word driven while no requester owns the display
//   - BLANK_MASK  : digit mask driven while no requester owns the display
// -----------------------------------------------------------------------------
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [31:0] BLANK_DATA = 32'h0000_0000;
  localparam logic [7:0]  BLANK_MASK = 8'h00;

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting at last_owner+1 and wrapping
// modulo N_REQ, the first index with req high wins.
// Ports:
//   req        in  N_REQ  level requests
//   last_owner in  OW     index of the most recent owner
//   winner     out OW     selected index (0 when no request is pending)
//   any        out 1      at least one request is high
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int OW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    last_owner,
  output logic [OW-1:0]    winner,
  output logic             any
);

  logic          found;
  logic [OW-1:0] idx;

  // The previous owner is visited last (offset N_REQ), so it can only win
  // again when nobody else is requesting.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(last_owner) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/disp_share_arbiter.sv
// -----------------------------------------------------------------------------
// disp_share_arbiter
// Time-shares the 8-digit seven-segment display path among N_REQ requesters.
// One owner at a time is chosen round-robin; an owner keeps the grant for at
// least MIN_HOLD cycles and is rotated out after MAX_HOLD cycles when another
// requester is waiting. GAP_CYCLES blank cycles separate consecutive owners.
//
// Ports:
//   clk        in  1          system clock
//   reset      in  1          synchronous, active-high reset
//   req        in  N_REQ      level request per requester
//   req_data   in  32*N_REQ   hex value per lane, lane i = [32i+31:32i]
//   req_mask   in  8*N_REQ    digit enables per lane, lane i = [8i+7:8i]
//   grant      out N_REQ      one-hot current owner, zero when none
//   owner      out OW         index of the current or last owner
//   busy       out 1          high in GRANT and GAP
//   disp_data  out 32         registered value to the display driver
//   disp_mask  out 8          registered digit enables (0 = all blank)
//
// Build option:
//   DISP_ARB_PREEMPT_EN  when defined, requester 0 is urgent: it forces an
//                        owner past its minimum hold into GAP, and it is
//                        checked first when arbitrating at the end of a GAP.
// -----------------------------------------------------------------------------
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MIN_HOLD   = 4,
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [32*N_REQ-1:0]        req_data,
  input  logic [8*N_REQ-1:0]         req_mask,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [31:0]                disp_data,
  output logic [7:0]                 disp_mask
);

  localparam int OW = $clog2(N_REQ);
  localparam int TW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_HOLD - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state;
  logic [OW-1:0] last_owner;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;

  logic [OW-1:0] rr_winner;
  logic          any_req;
  logic [OW-1:0] pick;
  logic [31:0]   pick_data;
  logic [7:0]    pick_mask;
  logic [31:0]   own_data;
  logic [7:0]    own_mask;
  logic          others;
  logic          preempt;
  logic          leave;
  logic          gap_last;
  logic          enter;

  // Timer saturates so a sole requester can hold forever without wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v >= MAX_LAST) ? MAX_LAST : v + TW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (rr_winner),
    .any        (any_req)
  );

  always_comb begin
    pick = rr_winner;
`ifdef DISP_ARB_PREEMPT_EN
    if (state == GAP && req[0]) begin
      pick = '0;
    end
`endif
  end

`ifdef DISP_ARB_PREEMPT_EN
  assign preempt = req[0] && (owner != '0);
`else
  assign preempt = 1'b0;
`endif

  assign pick_data = req_data[pick*32 +: 32];
  assign pick_mask = req_mask[pick*8 +: 8];
  assign own_data  = req_data[owner*32 +: 32];
  assign own_mask  = req_mask[owner*8 +: 8];

  // grant is one-hot on the owner while in GRANT, so this is "anyone else".
  assign others   = |(req & ~grant);
  assign leave    = (timer >= MIN_LAST) &&
                    (!req[owner] || ((timer >= MAX_LAST) && others) || preempt);
  assign gap_last = (gap_cnt == GAP_LAST);
  assign enter    = any_req && ((state == IDLE) || (state == GAP && gap_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      disp_data  <= BLANK_DATA;
      disp_mask  <= BLANK_MASK;
      last_owner <= OW'(N_REQ - 1);
      timer      <= '0;
      gap_cnt    <= '0;
    end else if (enter) begin
      state      <= GRANT;
      grant      <= onehot(pick);
      owner      <= pick;
      last_owner <= pick;
      busy       <= 1'b1;
      disp_data  <= pick_data;
      disp_mask  <= pick_mask;
      timer      <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant     <= '0;
          busy      <= 1'b0;
          disp_data <= BLANK_DATA;
          disp_mask <= BLANK_MASK;
        end
        GRANT: begin
          if (leave) begin
            state     <= GAP;
            grant     <= '0;
            disp_data <= BLANK_DATA;
            disp_mask <= BLANK_MASK;
            gap_cnt   <= '0;
          end else begin
            // Display keeps tracking the owner's lane even after it drops req.
            disp_data <= own_data;
            disp_mask <= own_mask;
            timer     <= sat_inc(timer);
          end
        end
        GAP: begin
          if (gap_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          busy      <= 1'b0;
          disp_data <= BLANK_DATA;
          disp_mask <= BLANK_MASK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_disp_share_arbiter
// Directed testbench for disp_share_arbiter with default parameters
// (N_REQ=4, MIN_HOLD=4, MAX_HOLD=16, GAP_CYCLES=2).
// Fixed lanes: 0 = 00001111/0F, 1 = d1/FF, 2 = 00002222/33, 3 = 33333333/F0.
// -----------------------------------------------------------------------------
module tb_disp_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [31:0]  req_mask;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic [31:0]  disp_data;
  logic [7:0]   disp_mask;

  logic [31:0]  d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_data = {32'h3333_3333, 32'h0000_2222, d1, 32'h0000_1111};
  assign req_mask = {8'hF0, 8'h33, 8'hFF, 8'h0F};

  disp_share_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .disp_data (disp_data),
    .disp_mask (disp_mask)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] d1v;
    logic [3:0]  eg;
    logic [1:0]  eo;
    logic        eb;
    logic [31:0] ed;
    logic [7:0]  em;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Per-cycle model of two requesters alternating: grants of 16 cycles
  // separated by 2-cycle blank gaps.
  task automatic rotate_check(input string name, input logic [3:0] req_first,
                              input logic [3:0] req_held,
                              input logic [3:0] ga, input logic [7:0] ma,
                              input logic [3:0] gb, input logic [7:0] mb,
                              input int ncyc);
    logic [3:0] eg;
    logic [7:0] em;
    int seg, per;
    for (int c = 0; c < ncyc; c++) begin
      req = (c == 0) ? req_first : req_held;
      step();
      seg = c % 18;
      per = c / 18;
      if (seg < 16) begin
        eg = (per % 2 == 0) ? ga : gb;
        em = (per % 2 == 0) ? ma : mb;
      end else begin
        eg = 4'b0000;
        em = 8'h00;
      end
      chk($sformatf("%s c%0d", name, c), {51'd0, busy, eg == grant ? grant : grant, disp_mask},
          {51'd0, 1'b1, eg, em});
    end
  endtask

  int n2, ng, guard, bad;

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    d1    = 32'hDEAD_BEEF;

    //          rst   req      d1            grant    own   busy  data          mask
    vecs[0]  = '{1'b1, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd0, 1'b0, 32'h00000000, 8'h00};
    vecs[1]  = '{1'b0, 4'b0010, 32'hDEADBEEF, 4'b0010, 2'd1, 1'b1, 32'hDEADBEEF, 8'hFF};
    vecs[2]  = '{1'b0, 4'b0010, 32'hDEADBEEF, 4'b0010, 2'd1, 1'b1, 32'hDEADBEEF, 8'hFF};
    vecs[3]  = '{1'b0, 4'b0010, 32'h12345678, 4'b0010, 2'd1, 1'b1, 32'h12345678, 8'hFF};
    vecs[4]  = '{1'b0, 4'b0010, 32'hDEADBEEF, 4'b0010, 2'd1, 1'b1, 32'hDEADBEEF, 8'hFF};
    vecs[5]  = '{1'b1, 4'b0010, 32'hDEADBEEF, 4'b0000, 2'd0, 1'b0, 32'h00000000, 8'h00};
    vecs[6]  = '{1'b0, 4'b1111, 32'hDEADBEEF, 4'b0001, 2'd0, 1'b1, 32'h00001111, 8'h0F};
    vecs[7]  = '{1'b1, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd0, 1'b0, 32'h00000000, 8'h00};
    vecs[8]  = '{1'b0, 4'b0100, 32'hDEADBEEF, 4'b0100, 2'd2, 1'b1, 32'h00002222, 8'h33};
    vecs[9]  = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0100, 2'd2, 1'b1, 32'h00002222, 8'h33};
    vecs[10] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0100, 2'd2, 1'b1, 32'h00002222, 8'h33};
    vecs[11] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0100, 2'd2, 1'b1, 32'h00002222, 8'h33};
    vecs[12] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd2, 1'b1, 32'h00000000, 8'h00};
    vecs[13] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd2, 1'b1, 32'h00000000, 8'h00};
    vecs[14] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd2, 1'b0, 32'h00000000, 8'h00};
    vecs[15] = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd2, 1'b0, 32'h00000000, 8'h00};

    // Table: reset, single request, lane tracking, reset mid-grant,
    // early release with minimum hold, gap then idle.
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].rq;
      d1    = vecs[i].d1v;
      step();
      chk($sformatf("vec%0d", i),
          {17'd0, grant, owner, busy, disp_data, disp_mask},
          {17'd0, vecs[i].eg, vecs[i].eo, vecs[i].eb, vecs[i].ed, vecs[i].em});
    end

    // Sole requester holds well past MAX_HOLD.
    reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      req = 4'b0010;
      step();
      if (grant !== 4'b0010 || disp_data !== 32'hDEAD_BEEF) bad++;
    end
    chk("sole_hold_bad_cycles", 64'(bad), 64'd0);

    // Rotation between 0 and 1.
    reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
    rotate_check("rotate", 4'b0011, 4'b0011, 4'b0001, 8'h0F, 4'b0010, 8'hFF, 54);

    // Wrap-around: owner 3 first, then 0, then 3 again.
    reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
    rotate_check("wrap", 4'b1000, 4'b1001, 4'b1000, 8'hF0, 4'b0001, 8'h0F, 54);

    // Requester 0 rises while owner 2 is at timer 5.
    reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
    req = 4'b0100;
    step();
    n2 = 0; guard = 0;
    while (grant == 4'b0100 && guard < 40) begin
      n2++;
      req = (n2 >= 6) ? 4'b0101 : 4'b0100;
      step();
      guard++;
    end
`ifdef DISP_ARB_PREEMPT_EN
    chk("preempt_owner2_cycles", 64'(n2), 64'd6);
`else
    chk("preempt_owner2_cycles", 64'(n2), 64'd16);
`endif
    ng = 0; guard = 0;
    while (grant == 4'b0000 && busy && guard < 10) begin
      if (disp_mask !== 8'h00) bad++;
      ng++;
      step();
      guard++;
    end
    chk("preempt_gap_cycles", 64'(ng), 64'd2);
    chk("preempt_next_owner", {56'd0, grant, 2'd0, owner}, {56'd0, 4'b0001, 2'd0, 2'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
